multi_stack: RTL
================

MULTI_STACK -- requirements
Module: multi_stack

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 32, entries per channel (power of two, >=2).
REQ-003 SHALL have parameter CHANNELS, default 4, number of independent LIFO stacks (>=1).
REQ-004 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port ch_sel  input  max(1,$clog2(CHANNELS))  channel addressed by push/pop/peek this cycle.
REQ-007 SHALL have port push  input  1  write data_in onto the top of the selected channel.
REQ-008 SHALL have port pop  input  1  remove the top of the selected channel and return it.
REQ-009 SHALL have port peek  input  1  return the top of the selected channel without removing it.
REQ-010 SHALL have port data_in  input  DATA_W  push data.
REQ-011 SHALL have port err_clr  input  1  clear the sticky error flags.
REQ-012 SHALL have port data_out  output  DATA_W  registered read data.
REQ-013 SHALL have port data_valid  output  1  data_out holds a valid pop/peek result this cycle.
REQ-014 SHALL have port full  output  CHANNELS  per-channel, bit c=1 when channel c count==DEPTH.
REQ-015 SHALL have port empty  output  CHANNELS  per-channel, bit c=1 when channel c count==0.
REQ-016 SHALL have port count  output  $clog2(DEPTH+1)  occupancy of channel ch_sel (combinational from registered counts).
REQ-017 SHALL have port err_overflow  output  1  sticky: push to a full channel occurred.
REQ-018 SHALL have port err_underflow  output  1  sticky: pop/peek of an empty channel occurred.

Function
REQ-019 SHALL keep one independent count per channel; storage is CHANNELS*DEPTH words, channel c entry i at address c*DEPTH+i.
REQ-020 SHALL apply at most one operation per cycle, to channel ch_sel only; other channels are unchanged.
REQ-021 SHALL on push alone (not full) write data_in at entry count and increment count; data_valid=0 next cycle.
REQ-022 SHALL on pop alone (not empty) decrement count and present entry count-1 on data_out with data_valid=1 one cycle later (latency 1).
REQ-023 SHALL on peek alone (not empty) present entry count-1 on data_out with data_valid=1 one cycle later; count unchanged; peek is ignored when push or pop is asserted.
REQ-024 SHALL on push+pop to a non-empty channel replace the top: output the old top (data_valid=1 next cycle), write data_in to entry count-1, count unchanged; allowed even when full, with no overflow.
REQ-025 SHALL on push+pop to an empty channel pass data_in to data_out next cycle with data_valid=1, with no storage or count change and no error.
REQ-026 SHALL ignore push alone to a full channel (no write, count unchanged) and set err_overflow.
REQ-027 SHALL ignore pop alone or peek to an empty channel, keep data_valid=0 and data_out unchanged, and set err_underflow.
REQ-028 SHALL never wrap count or addresses; count stays within 0..DEPTH.
REQ-029 SHALL hold data_out at its last value when data_valid=0.
REQ-030 SHALL update full/empty in the same cycle the count register changes (visible the cycle after the operation).
REQ-031 SHALL clear both errors on err_clr; if a new error event occurs in the same cycle, the set takes priority.
REQ-032 SHALL let a pop in cycle N+1 return data pushed in cycle N (no read-after-write hazard).

Reset
REQ-033 SHALL on rst set all counts=0, empty='1, full='0, data_out=0, data_valid=0, err_overflow=0, err_underflow=0.
REQ-034 SHALL give rst priority over all inputs; an operation in a reset cycle is discarded; memory contents need not be cleared.

Verification
REQ-035 SHALL verify with DATA_W=8, DEPTH=4, CHANNELS=2: push 0x11,0x22 on ch0, then pop ch0 twice -> data_out 0x22 then 0x11, each valid 1 cycle after its pop, then empty[0]=1.
REQ-036 SHALL verify fill: push 4 words on ch1 -> full[1]=1, empty[0]=1 unaffected; a fifth push -> count stays 4, err_overflow=1; err_clr -> err_overflow=0.
REQ-037 SHALL verify underflow: pop ch0 when empty -> data_valid=0, err_underflow=1, count=0.
REQ-038 SHALL verify replace on full ch1 (top 0x44): push 0x55 with pop -> data_out 0x44, count 4, no error; next peek -> 0x55.
REQ-039 SHALL verify push+pop on empty ch0 with data_in 0x7E -> data_out 0x7E with valid=1 next cycle, empty[0] stays 1.
REQ-040 SHALL verify rst asserted mid-sequence with pop pending -> next cycle all counts 0, data_valid=0, errors 0.

Source files
------------

// File: rtl/multi_stack.sv
// Bank of CHANNELS independent LIFO stacks sharing one storage array.
// One push/pop/peek/replace per cycle on channel ch_sel; read data is registered.
module multi_stack #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 32,
  parameter int CHANNELS = 4
) (
  input  logic                                           clk,
  input  logic                                           rst,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] ch_sel,
  input  logic                                           push,
  input  logic                                           pop,
  input  logic                                           peek,
  input  logic [DATA_W-1:0]                              data_in,
  input  logic                                           err_clr,
  output logic [DATA_W-1:0]                              data_out,
  output logic                                           data_valid,
  output logic [CHANNELS-1:0]                            full,
  output logic [CHANNELS-1:0]                            empty,
  output logic [$clog2(DEPTH+1)-1:0]                     count,
  output logic                                           err_overflow,
  output logic                                           err_underflow
);

  localparam int SW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int IW    = $clog2(DEPTH);
  localparam int WORDS = CHANNELS * DEPTH;
  localparam int AW    = (WORDS > 1) ? $clog2(WORDS) : 1;

  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [2:0] {
    OP_NONE,
    OP_PUSH,
    OP_POP,
    OP_PEEK,
    OP_REPLACE,
    OP_PASS
  } op_e;

  logic [DATA_W-1:0] mem [WORDS];
  logic [CW-1:0]     cnt [CHANNELS];

  logic              ch_ok;
  logic [SW-1:0]     ch_idx;
  logic [CW-1:0]     sel_cnt;
  logic              sel_full;
  logic              sel_empty;
  logic [IW-1:0]     top_idx;
  logic [IW-1:0]     wr_idx;
  logic [AW-1:0]     top_addr;
  logic [AW-1:0]     push_addr;
  logic [AW-1:0]     mem_waddr;
  logic              mem_we;
  op_e               op;
  logic              set_ov;
  logic              set_un;

  // A ch_sel beyond the last channel (non power-of-two CHANNELS) is a no-op.
  assign ch_ok     = (32'(ch_sel) < CHANNELS);
  assign ch_idx    = ch_ok ? ch_sel : '0;
  assign sel_cnt   = cnt[ch_idx];
  assign sel_full  = (sel_cnt == FULL_CNT);
  assign sel_empty = (sel_cnt == '0);
  assign count     = ch_ok ? sel_cnt : '0;

  // Channel c entry i lives at c*DEPTH+i; DEPTH is a power of two, so the
  // address is simply the channel index concatenated with the entry index.
  assign top_idx   = IW'(sel_cnt - CW'(1));
  assign wr_idx    = IW'(sel_cnt);
  assign top_addr  = AW'({ch_idx, top_idx});
  assign push_addr = AW'({ch_idx, wr_idx});

  always_comb begin
    for (int c = 0; c < CHANNELS; c++) begin
      full[c]  = (cnt[c] == FULL_CNT);
      empty[c] = (cnt[c] == '0);
    end
  end

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if/else tree can leave a value held and infer a latch.
  always_comb begin
    op     = OP_NONE;
    set_ov = 1'b0;
    set_un = 1'b0;
    if (ch_ok) begin
      if (push && pop) begin
        op = sel_empty ? OP_PASS : OP_REPLACE;
      end else if (push) begin
        if (sel_full) set_ov = 1'b1;
        else          op     = OP_PUSH;
      end else if (pop || peek) begin
        if (sel_empty) set_un = 1'b1;
        else           op     = pop ? OP_POP : OP_PEEK;
      end
    end
  end

  assign mem_we    = (op == OP_PUSH) || (op == OP_REPLACE);
  assign mem_waddr = (op == OP_PUSH) ? push_addr : top_addr;

  // NOTE: storage has no reset; validity is tracked entirely by the counts,
  // which keeps the array mappable onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[mem_waddr] <= data_in;
  end

  // NOTE: sequential state uses non-blocking assignments only, so the read of
  // the old top during a replace sees the pre-write contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) cnt[c] <= '0;
      data_out      <= '0;
      data_valid    <= 1'b0;
      err_overflow  <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      case (op)
        OP_PUSH: begin
          cnt[ch_idx] <= sel_cnt + CW'(1);
        end
        OP_POP: begin
          cnt[ch_idx] <= sel_cnt - CW'(1);
          data_out    <= mem[top_addr];
          data_valid  <= 1'b1;
        end
        OP_PEEK, OP_REPLACE: begin
          data_out   <= mem[top_addr];
          data_valid <= 1'b1;
        end
        OP_PASS: begin
          data_out   <= data_in;
          data_valid <= 1'b1;
        end
        default: ;
      endcase
      // A new error event wins over a simultaneous clear.
      err_overflow  <= set_ov | (err_overflow  & ~err_clr);
      err_underflow <= set_un | (err_underflow & ~err_clr);
    end
  end

endmodule
